// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts one function code per handshake, broadcasts it registered,
// and runs DIVU/MULTU for a configured iteration count followed by a one-cycle HI/LO commit.
module alu_op_sequencer #(
    parameter int                 FUNCT_W     = 6,
    parameter int                 DIV_CYCLES  = 32,
    parameter int                 MUL_CYCLES  = 32,
    parameter int                 CNT_W       = 7,
    parameter logic [FUNCT_W-1:0] DIVU_CODE   = 6'b011011,
    parameter logic [FUNCT_W-1:0] MULTU_CODE  = 6'b011001,
    parameter logic [FUNCT_W-1:0] COMMIT_CODE = 6'b111111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FUNCT_W-1:0] funct_in,
    input  logic               funct_valid,
    output logic               funct_ready,
    output logic [FUNCT_W-1:0] op_out,
    output logic               op_valid,
    output logic               hilo_we,
    output logic               busy,
    output logic [CNT_W-1:0]   iter
);

    // The iteration counter must reach N without wrapping, so N must fit in CNT_W bits.
    if (DIV_CYCLES < 1 || DIV_CYCLES > (2 ** CNT_W) - 1) begin : g_badDivCycles
        $error("alu_op_sequencer: DIV_CYCLES must be in 1..2^CNT_W-1");
    end
    if (MUL_CYCLES < 1 || MUL_CYCLES > (2 ** CNT_W) - 1) begin : g_badMulCycles
        $error("alu_op_sequencer: MUL_CYCLES must be in 1..2^CNT_W-1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [FUNCT_W-1:0] r_op;
    logic [FUNCT_W-1:0] w_opNext;
    logic               r_opValid;
    logic               w_opValidNext;
    logic [CNT_W-1:0]   r_iter;
    logic [CNT_W-1:0]   w_iterNext;
    logic [CNT_W-1:0]   r_limit;
    logic [CNT_W-1:0]   w_limitNext;
    logic               w_accept;

    assign w_accept = funct_valid && funct_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_opValid <= 1'b0;
            r_iter    <= '0;
            r_limit   <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_op      <= w_opNext;
            r_opValid <= w_opValidNext;
            r_iter    <= w_iterNext;
            r_limit   <= w_limitNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_opNext      = r_op;
        w_opValidNext = 1'b0;
        w_iterNext    = r_iter;
        w_limitNext   = r_limit;
        case (r_state)
            S_IDLE: begin
                w_iterNext = '0;
                if (w_accept) begin
                    w_opNext      = funct_in;
                    w_opValidNext = 1'b1;
                    if (funct_in == DIVU_CODE) begin
                        w_stateNext = S_RUN;
                        w_iterNext  = CNT_W'(1);
                        w_limitNext = CNT_W'(DIV_CYCLES);
                    end else if (funct_in == MULTU_CODE) begin
                        w_stateNext = S_RUN;
                        w_iterNext  = CNT_W'(1);
                        w_limitNext = CNT_W'(MUL_CYCLES);
                    end
                end
            end
            S_RUN: begin
                w_opValidNext = 1'b1;
                if (r_iter == r_limit) begin
                    // The commit cycle re-purposes the op bus to open the HI/LO register.
                    w_stateNext = S_COMMIT;
                    w_iterNext  = '0;
                    w_opNext    = COMMIT_CODE;
                end else begin
                    w_iterNext = r_iter + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                w_stateNext = S_IDLE;
                w_iterNext  = '0;
            end
            default: begin
                w_stateNext = S_IDLE;
                w_iterNext  = '0;
            end
        endcase
    end

    always_comb begin
        funct_ready = (r_state == S_IDLE) && !rst;
        busy        = (r_state != S_IDLE);
        hilo_we     = (r_state == S_COMMIT);
        op_out      = r_op;
        op_valid    = r_opValid;
        iter        = r_iter;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus random traffic,
// compared each cycle against a timeline model of the op phases.
module tb_alu_op_sequencer;

    localparam int         FW        = 6;
    localparam int         CW        = 7;
    localparam int         DIVN      = 32;
    localparam int         MULN      = 4;
    localparam logic [5:0] DIVU_OP   = 6'h1B;
    localparam logic [5:0] MULTU_OP  = 6'h19;
    localparam logic [5:0] COMMIT_OP = 6'h3F;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] funct_in;
    logic          funct_valid;
    logic          funct_ready;
    logic [FW-1:0] op_out;
    logic          op_valid;
    logic          hilo_we;
    logic          busy;
    logic [CW-1:0] iter;

    int checkCount = 0;
    int errorCount = 0;
    int cycleNum   = 0;

    // Model: mPhase counts edges since a multi-cycle op was accepted (0 = no op running).
    int         mPhase;
    int         mN;
    logic [5:0] mCode;
    logic [5:0] mLastOp;
    bit         mValid;

    alu_op_sequencer #(
        .FUNCT_W    (FW),
        .DIV_CYCLES (DIVN),
        .MUL_CYCLES (MULN),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .funct_in    (funct_in),
        .funct_valid (funct_valid),
        .funct_ready (funct_ready),
        .op_out      (op_out),
        .op_valid    (op_valid),
        .hilo_we     (hilo_we),
        .busy        (busy),
        .iter        (iter)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     tag, cycleNum, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check the current outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input bit rstV, input bit fvV, input logic [5:0] finV);
        int expOp, expValid, expIter, expBusy, expHilo, expReady;
        rst         = rstV;
        funct_valid = fvV;
        funct_in    = finV;
        if (mPhase == 0) begin
            expOp = mLastOp; expValid = mValid; expIter = 0;
            expBusy = 0; expHilo = 0; expReady = rstV ? 0 : 1;
        end else if (mPhase <= mN) begin
            expOp = mCode; expValid = 1; expIter = mPhase;
            expBusy = 1; expHilo = 0; expReady = 0;
        end else begin
            expOp = COMMIT_OP; expValid = 1; expIter = 0;
            expBusy = 1; expHilo = 1; expReady = 0;
        end
        @(negedge clk);
        checkOutput("op_out",      op_out,      expOp);
        checkOutput("op_valid",    op_valid,    expValid);
        checkOutput("iter",        iter,        expIter);
        checkOutput("busy",        busy,        expBusy);
        checkOutput("hilo_we",     hilo_we,     expHilo);
        checkOutput("funct_ready", funct_ready, expReady);
        @(posedge clk);
        if (rstV) begin
            mPhase = 0; mLastOp = '0; mValid = 0;
        end else if (mPhase == mN + 1) begin
            mPhase = 0; mLastOp = COMMIT_OP; mValid = 0;
        end else if (mPhase > 0) begin
            mPhase++;
        end else if (fvV) begin
            mLastOp = finV;
            mValid  = 1;
            if (finV == DIVU_OP || finV == MULTU_OP) begin
                mCode  = finV;
                mN     = (finV == DIVU_OP) ? DIVN : MULN;
                mPhase = 1;
            end
        end else begin
            mValid = 0;
        end
        cycleNum++;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] singles [5];
        logic [5:0] pick;
        bit         rndRst;
        bit         rndValid;
        singles = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};

        rst = 1'b1; funct_valid = 1'b0; funct_in = '0;
        mPhase = 0; mN = 1; mCode = '0; mLastOp = '0; mValid = 0;
        @(posedge clk);
        #1;

        $display("[TB] reset then idle");
        applyStimulus(1, 0, 6'h00);
        applyStimulus(1, 0, 6'h00);
        applyStimulus(0, 0, 6'h00);
        applyStimulus(0, 0, 6'h00);

        $display("[TB] single-cycle stream");
        foreach (singles[i]) applyStimulus(0, 1, singles[i]);
        applyStimulus(0, 0, 6'h00);
        applyStimulus(0, 0, 6'h00);

        $display("[TB] DIVU with default iteration count");
        applyStimulus(0, 1, DIVU_OP);
        for (int i = 0; i < DIVN + 3; i++) applyStimulus(0, 0, 6'h00);

        $display("[TB] MULTU with a code held during busy");
        applyStimulus(0, 1, MULTU_OP);
        for (int i = 0; i < MULN + 3; i++) applyStimulus(0, 1, 6'h20);
        applyStimulus(0, 0, 6'h00);
        applyStimulus(0, 0, 6'h00);

        $display("[TB] reset in the middle of DIVU");
        applyStimulus(0, 1, DIVU_OP);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 6'h00);
        applyStimulus(1, 0, 6'h00);
        for (int i = 0; i < DIVN + 4; i++) applyStimulus(0, 0, 6'h00);

        $display("[TB] COMMIT code as a single-cycle op");
        applyStimulus(0, 1, COMMIT_OP);
        applyStimulus(0, 0, 6'h00);
        applyStimulus(0, 0, 6'h00);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            rndRst   = ($urandom_range(0, 79) == 0);
            rndValid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0:       pick = DIVU_OP;
                1, 2:    pick = MULTU_OP;
                3:       pick = COMMIT_OP;
                default: pick = 6'($urandom_range(0, 63));
            endcase
            applyStimulus(rndRst, rndValid, pick);
        end
        for (int i = 0; i < DIVN + 4; i++) applyStimulus(0, 0, 6'h00);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Parametrised successor to the single-op ALU control stage. Accepts one function code per handshake and broadcasts it, registered, to the ALU, shifter, divider and HI/LO mux.
- Runs multi-cycle operations (DIVU, MULTU) for separately configured cycle counts. Raises a one-cycle HI/LO commit at the end of each, and blocks new codes while busy.
- Sits between instruction decode and the datapath function units.

Parameters:
- FUNCT_W, 6, width of function code and broadcast op bus.
- DIV_CYCLES, 32, iterations for DIVU before HI/LO commit (legal range 1..2^CNT_W-1).
- MUL_CYCLES, 32, iterations for MULTU before HI/LO commit (legal range 1..2^CNT_W-1).
- CNT_W, 7, iteration counter width.
- DIVU_CODE, 6'b011011, function code of unsigned divide.
- MULTU_CODE, 6'b011001, function code of unsigned multiply.
- COMMIT_CODE, 6'b111111, op bus value that opens the HI/LO register.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- funct_in  input  FUNCT_W  function code from decode.
- funct_valid  input  1  funct_in is valid this cycle.
- funct_ready  output  1  sequencer can accept a code this cycle.
- op_out  output  FUNCT_W  registered op broadcast to ALU/SHT/DIV/MUX.
- op_valid  output  1  op_out is meaningful this cycle.
- hilo_we  output  1  HI/LO write enable; high only in the commit cycle.
- busy  output  1  a multi-cycle op is in progress, including its commit cycle.
- iter  output  CNT_W  current iteration index; 0 when not running.

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high; rst is sampled on the clk rising edge.
  - Reset is dominant over all other inputs.
  - Reset values: state=IDLE, op_out=0, op_valid=0, hilo_we=0, busy=0, iter=0, funct_ready=1 (the first cycle after rst deasserts).
  - Reset mid-operation abandons the op; no hilo_we is produced.
- States: IDLE, RUN, COMMIT.
- Combinational outputs: funct_ready = (state==IDLE) && !rst. busy = (state!=IDLE).
- IDLE, accept (funct_valid && funct_ready):
  - Register op_out=funct_in and op_valid=1; both are visible the cycle after acceptance (latency 1).
  - If funct_in is DIVU_CODE or MULTU_CODE: go to RUN, iter=1, latch limit N=DIV_CYCLES or MUL_CYCLES.
  - Otherwise (single-cycle op): stay IDLE. Back-to-back single-cycle codes are accepted every cycle.
- IDLE, no accept: op_valid=0. op_out holds its last value.
- RUN:
  - op_out holds the multi-cycle code and op_valid=1.
  - Each cycle: if iter==N go to COMMIT and set iter=0; else iter=iter+1.
  - funct_valid is ignored; the code is not stored. The upstream stage must hold it until funct_ready.
- COMMIT (exactly one cycle):
  - op_out=COMMIT_CODE, op_valid=1, hilo_we=1.
  - Next state IDLE. funct_ready is 0 during COMMIT.
- Timing for a multi-cycle op accepted at edge E0:
  - op_out=code from E0 through E0+N.
  - hilo_we=1 in the cycle after edge E0+N.
  - funct_ready=1 again after edge E0+N+1.
- Edge cases:
  - A single-cycle code equal to COMMIT_CODE is passed through unchanged with hilo_we=0. Only COMMIT state drives hilo_we.
  - iter wraps never: N < 2^CNT_W is a parameter legality rule.
  - The RTL must flag N==0 or N >= 2^CNT_W as illegal at elaboration.
- No X propagation: funct_in is not sampled unless funct_valid.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release -> op_out=0, op_valid=0, hilo_we=0, busy=0, iter=0, funct_ready=1.
- Single-cycle stream: codes 0x24, 0x25, 0x20, 0x22, 0x2A on consecutive cycles with funct_valid=1 -> op_out shows each one cycle later, op_valid=1 throughout, busy=0, hilo_we never 1.
- DIVU with defaults: accept 0x1B at cycle 0 -> op_out=0x1B for cycles 1..32, iter runs 1..32, op_out=0x3F and hilo_we=1 in cycle 33 only, funct_ready=0 in cycles 1..33 and 1 in cycle 34.
- MULTU with MUL_CYCLES=4: accept 0x19 -> hilo_we pulse 5 cycles after acceptance. A 0x20 held with funct_valid during busy is accepted only once funct_ready=1, and op_out=0x20 follows the next cycle.
- Reset mid-DIVU: assert rst at iter=10 -> next cycle state=IDLE, op_valid=0, iter=0, and no hilo_we pulse ever occurs for that op.
- Passthrough of 0x3F as a single-cycle code -> op_out=0x3F, op_valid=1, hilo_we=0, busy=0.
